// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes and data-memory freeze/timeout.
// Define STALL_PERF_EN to add the saturating load-use, flush and memory-wait event counters.
module stall_flush_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_we,
    output logic        memwb_flush,
`ifdef STALL_PERF_EN
    output logic [31:0] load_use_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] mem_wait_cnt,
`endif
    output logic        mem_err
);

    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        StRun,
        StMemWait
    } state_e;

    // Which output row is driven this cycle, already resolved by priority.
    typedef enum logic [2:0] {
        RowRun,
        RowLoadUse,
        RowBranch,
        RowTimeout,
        RowFreeze
    } row_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic mem_pending;
    logic timeout_hit;
    logic freeze;
    row_e row;

    // An access still outstanding when the wait budget is spent is abandoned, not frozen again.
    always_comb begin
        mem_pending = dmem_req & ~dmem_ready;
        timeout_hit = (state_q == StMemWait) && (wait_cnt_q == TimeoutVal) && mem_pending;
        freeze      = mem_pending & ~timeout_hit;
    end

    always_comb begin
        if (freeze) begin
            row = RowFreeze;
        end else if (timeout_hit) begin
            row = RowTimeout;
        end else if (branch_taken) begin
            row = RowBranch;
        end else if (stall_req) begin
            row = RowLoadUse;
        end else begin
            row = RowRun;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | timeout_hit;
        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end
            end
            StMemWait: begin
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    // Completion, dropped request or timeout all return to RUN.
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        memwb_flush = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else begin
            unique case (row)
                RowFreeze: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    exmem_we    = 1'b0;
                    memwb_flush = 1'b1;
                end
                RowTimeout: begin
                    memwb_flush = 1'b1;
                end
                RowBranch: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                RowLoadUse: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end
                RowRun: begin
                end
            endcase
        end
        mem_err = rst_n & (mem_err_q | timeout_hit);
    end

`ifdef STALL_PERF_EN
    logic [31:0] load_use_cnt_q, load_use_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] mem_wait_cnt_q, mem_wait_cnt_d;

    always_comb begin
        load_use_cnt_d = load_use_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        mem_wait_cnt_d = mem_wait_cnt_q;
        if ((row == RowLoadUse) && (load_use_cnt_q != 32'hFFFF_FFFF)) begin
            load_use_cnt_d = load_use_cnt_q + 32'd1;
        end
        if ((row == RowBranch) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if ((row == RowFreeze) && (mem_wait_cnt_q != 32'hFFFF_FFFF)) begin
            mem_wait_cnt_d = mem_wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_use_cnt_q <= 32'd0;
            flush_cnt_q    <= 32'd0;
            mem_wait_cnt_q <= 32'd0;
        end else begin
            load_use_cnt_q <= load_use_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
        end
    end

    assign load_use_cnt = load_use_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign mem_wait_cnt = mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Scoreboard bench for stall_flush_ctrl (MEM_TIMEOUT=4); counter checks only when STALL_PERF_EN is set.
module tb_stall_flush_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_req = 1'b0;
    logic branch_taken = 1'b0;
    logic dmem_req = 1'b0;
    logic dmem_ready = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush, mem_err;
`ifdef STALL_PERF_EN
    logic [31:0] load_use_cnt, flush_cnt, mem_wait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush, mem_err}
    localparam logic [6:0] VRUN   = 7'b1100100;
    localparam logic [6:0] VSTALL = 7'b0001100;
    localparam logic [6:0] VBR    = 7'b1111100;
    localparam logic [6:0] VFRZ   = 7'b0000010;
    localparam logic [6:0] VTMO   = 7'b1100111;
    localparam logic [6:0] VRST   = 7'b0011010;
    localparam logic [6:0] VERR   = 7'b0000001;

    stall_flush_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_req    (stall_req),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_we     (exmem_we),
        .memwb_flush  (memwb_flush),
`ifdef STALL_PERF_EN
        .load_use_cnt (load_use_cnt),
        .flush_cnt    (flush_cnt),
        .mem_wait_cnt (mem_wait_cnt),
`endif
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_flush, mem_err};
    endfunction

    // Drive {stall_req, branch_taken, dmem_req, dmem_ready} for one cycle and queue the expectation.
    task automatic drive(input logic [3:0] in, input logic [6:0] exp);
        @(posedge clk);
        #1;
        {stall_req, branch_taken, dmem_req, dmem_ready} = in;
        exp_q.push_back(exp);
    endtask

    task automatic test_reset();
        logic [6:0] e;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(VRST);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), e);
        end
`ifdef STALL_PERF_EN
        n_cmp++;
        if ({load_use_cnt, flush_cnt, mem_wait_cnt} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     load_use_cnt, flush_cnt, mem_wait_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(VRUN);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL first_after_reset: got %b expected %b", obs(), e);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] ins [3] = '{4'b1000, 4'b0000, 4'b0000};
        logic [6:0] exps [3] = '{VSTALL, VRUN, VRUN};
        logic [6:0] e;
`ifdef STALL_PERF_EN
        logic [31:0] lu0 = load_use_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL load_use step %0d: got %b expected %b", i, obs(), e);
            end
        end
`ifdef STALL_PERF_EN
        n_cmp++;
        if (load_use_cnt !== lu0 + 32'd1) begin
            n_err++;
            $display("FAIL load_use_cnt: got %0d expected %0d", load_use_cnt, lu0 + 32'd1);
        end
`endif
    endtask

    task automatic test_branch_stall();
        logic [3:0] ins [3] = '{4'b1100, 4'b0100, 4'b0000};
        logic [6:0] exps [3] = '{VBR, VBR, VRUN};
        logic [6:0] e;
`ifdef STALL_PERF_EN
        logic [31:0] lu0 = load_use_cnt;
        logic [31:0] fl0 = flush_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL branch_stall step %0d: got %b expected %b", i, obs(), e);
            end
        end
`ifdef STALL_PERF_EN
        n_cmp++;
        if (load_use_cnt !== lu0 || flush_cnt !== fl0 + 32'd2) begin
            n_err++;
            $display("FAIL branch_counters: got lu=%0d fl=%0d expected lu=%0d fl=%0d",
                     load_use_cnt, flush_cnt, lu0, fl0 + 32'd2);
        end
`endif
    endtask

    task automatic test_mem_wait();
        logic [3:0] ins [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
        logic [6:0] exps [5] = '{VFRZ, VFRZ, VFRZ, VRUN, VRUN};
        logic [6:0] e;
`ifdef STALL_PERF_EN
        logic [31:0] mw0 = mem_wait_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL mem_wait step %0d: got %b expected %b", i, obs(), e);
            end
        end
`ifdef STALL_PERF_EN
        n_cmp++;
        if (mem_wait_cnt !== mw0 + 32'd3) begin
            n_err++;
            $display("FAIL mem_wait_cnt: got %0d expected %0d", mem_wait_cnt, mw0 + 32'd3);
        end
`endif
    endtask

    // Release with a stall honoured, then release by dropping dmem_req.
    task automatic test_mem_release();
        logic [3:0] ins [8] = '{4'b0010, 4'b1011, 4'b0000, 4'b0010, 4'b0000,
                                4'b0010, 4'b0011, 4'b0000};
        logic [6:0] exps [8] = '{VFRZ, VSTALL, VRUN, VFRZ, VRUN, VFRZ, VRUN, VRUN};
        logic [6:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL mem_release step %0d: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_freeze_priority();
        logic [3:0] ins [3] = '{4'b1110, 4'b0011, 4'b0000};
        logic [6:0] exps [3] = '{VFRZ, VRUN, VRUN};
        logic [6:0] e;
`ifdef STALL_PERF_EN
        logic [31:0] lu0 = load_use_cnt;
        logic [31:0] fl0 = flush_cnt;
        logic [31:0] mw0 = mem_wait_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL freeze_priority step %0d: got %b expected %b", i, obs(), e);
            end
        end
`ifdef STALL_PERF_EN
        n_cmp++;
        if (load_use_cnt !== lu0 || flush_cnt !== fl0 || mem_wait_cnt !== mw0 + 32'd1) begin
            n_err++;
            $display("FAIL freeze_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     load_use_cnt, flush_cnt, mem_wait_cnt, lu0, fl0, mw0 + 32'd1);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] ins [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b1100, 4'b0000};
        logic [6:0] exps [6] = '{VSTALL, VSTALL, VSTALL, VBR, VBR, VRUN};
        logic [6:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] ins [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0000, 4'b1000, 4'b0000};
        logic [6:0] exps [8] = '{VFRZ, VFRZ, VFRZ, VFRZ, VTMO,
                                 VRUN | VERR, VSTALL | VERR, VRUN | VERR};
        logic [6:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(ins[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL timeout step %0d: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [6:0] e;
        drive(4'b0010, VFRZ | VERR);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_wait enter: got %b expected %b", obs(), e);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(VRST);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_wait immediate: got %b expected %b", obs(), e);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {stall_req, branch_taken, dmem_req, dmem_ready} = 4'b0000;
        exp_q.push_back(VRUN);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_wait release: got %b expected %b", obs(), e);
        end
        drive(4'b0010, VFRZ);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_wait new_access: got %b expected %b", obs(), e);
        end
        drive(4'b0011, VRUN);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid_wait complete: got %b expected %b", obs(), e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_stall();
        test_mem_wait();
        test_mem_release();
        test_freeze_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of consecutive wait cycles for one data-memory access; legal range is 1..255.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall_req  input  1  load-use stall request from the ID-stage hazard detector.
REQ-005 branch_taken  input  1  EX-stage branch or jump redirect; the two younger instructions are wrong-path.
REQ-006 dmem_req  input  1  MEM stage holds a valid load or store this cycle.
REQ-007 dmem_ready  input  1  data memory completes the access this cycle.
REQ-008 pc_we  output  1  PC register write enable.
REQ-009 ifid_we  output  1  IF/ID register write enable.
REQ-010 ifid_flush  output  1  IF/ID register loads a NOP at the next edge.
REQ-011 idex_flush  output  1  ID/EX register loads a bubble (all control fields 0) at the next edge.
REQ-012 exmem_we  output  1  ID/EX and EX/MEM register write enable.
REQ-013 memwb_flush  output  1  MEM/WB register loads a bubble at the next edge.
REQ-014 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-015 The block SHALL implement FSM states RUN and MEM_WAIT.
REQ-016 In RUN with no requests, the block SHALL drive pc_we=1, ifid_we=1, exmem_we=1, and all flushes 0.
REQ-017 Freeze, when dmem_req=1 and dmem_ready=0 in either state, the block SHALL drive pc_we=0, ifid_we=0, exmem_we=0, memwb_flush=1, ifid_flush=0, and idex_flush=0 in the same cycle; freeze overrides every other request.
REQ-018 In RUN, a freeze condition SHALL move the FSM to MEM_WAIT at the next edge and load the wait counter with 1.
REQ-019 In MEM_WAIT with dmem_ready=1, the block SHALL drive the RUN outputs in that cycle and move the FSM to RUN at the next edge; branch_taken and stall_req SHALL be honoured in that cycle.
REQ-020 In MEM_WAIT without dmem_ready, the wait counter SHALL increment by 1 each cycle.
REQ-021 When the wait counter equals MEM_TIMEOUT, the block SHALL set mem_err=1, drive the RUN outputs with memwb_flush=1 for that cycle, and move the FSM to RUN (access abandoned).
REQ-022 A branch (branch_taken=1, no freeze) SHALL drive pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, and exmem_we=1.
REQ-023 Branch SHALL win over stall_req in the same cycle, because the stalled ID instruction is wrong-path.
REQ-024 A load-use stall (stall_req=1, no branch, no freeze) SHALL drive pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1, ifid_flush=0, and memwb_flush=0, giving exactly one bubble per cycle of request.
REQ-025 Priority SHALL be: freeze > timeout > branch > load-use > run.
REQ-026 Outputs SHALL be combinational from the FSM state, the wait counter, and the inputs, with zero-cycle latency; only the FSM state, wait counter, mem_err, and counters are registered.
REQ-027 A dmem_req that deasserts while in MEM_WAIT SHALL be treated as completion (same as dmem_ready=1).

Reset
REQ-028 While rst_n=0, the block SHALL force the FSM to RUN, the wait counter to 0, and mem_err to 0.
REQ-029 While rst_n=0, outputs SHALL be pc_we=0, ifid_we=0, exmem_we=0, ifid_flush=1, idex_flush=1, and memwb_flush=1.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the access immediately, with no mem_err.
REQ-031 The first cycle after reset release SHALL behave as RUN.

Configuration
REQ-032 With STALL_PERF_EN defined, the block SHALL add outputs load_use_cnt, flush_cnt, and mem_wait_cnt (output, 32 bits each), reset to 0.
REQ-033 With STALL_PERF_EN defined, each counter SHALL increment by 1 in each cycle its condition drives the outputs (load-use row, branch row, freeze row respectively) and saturate at 0xFFFFFFFF.
REQ-034 Without STALL_PERF_EN, the counter ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Load-use: stall_req=1 for 1 cycle in RUN -> that cycle pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; the next cycle is all-run with stall_req=0.
REQ-036 Branch plus stall: branch_taken=1 and stall_req=1 together -> pc_we=1, ifid_flush=1, idex_flush=1; load_use_cnt unchanged and flush_cnt +1 (if STALL_PERF_EN).
REQ-037 Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_flush=1, release in cycle 4, FSM back to RUN in cycle 5, and mem_wait_cnt=3.
REQ-038 Timeout: MEM_TIMEOUT=4 with dmem_ready held low -> frozen cycles 1-4, then mem_err=1 in cycle 5 and the FSM in RUN; mem_err stays 1 until rst_n=0.
REQ-039 Freeze priority: branch_taken=1, stall_req=1, dmem_req=1, dmem_ready=0 -> freeze outputs only, with no flush of IF/ID or ID/EX.
REQ-040 Reset mid-wait: rst_n pulled low in MEM_WAIT -> reset output values immediately and mem_err=0; after release, outputs are all-run.
